// File: rtl/gecko_load_writeback_pkg.sv
// Shared gecko types for the load-completion stage: memory ops, queue entries,
// writeback records and the load-data formatter.
package gecko_load_writeback_pkg;

  typedef enum logic [2:0] {
    LOAD_LB  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LW  = 3'b010,
    LOAD_LBU = 3'b100,
    LOAD_LHU = 3'b101
  } gecko_load_op_t;

  typedef struct packed {
    logic [4:0]     addr;
    gecko_load_op_t op;
    logic [1:0]     offset;
  } gecko_mem_operation_t;

  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  addr;
    logic        speculative;
  } gecko_operation_t;

  typedef struct packed {
    logic branch;
  } gecko_branch_signal_t;

  typedef struct packed {
    gecko_mem_operation_t op;
    logic                 speculative;
    logic                 killed;
  } gecko_load_entry_t;

  // Extracts the addressed byte/half from an aligned word and extends it.
  function automatic logic [31:0] gecko_get_load_result(input logic [31:0] word,
                                                        input logic [1:0] offset,
                                                        input gecko_load_op_t op);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {offset, 3'b000});
    h = offset[1] ? word[31:16] : word[15:0];
    case (op)
      LOAD_LB:  r = {{24{b[7]}}, b};
      LOAD_LBU: r = {24'd0, b};
      LOAD_LH:  r = {{16{h[15]}}, h};
      LOAD_LHU: r = {16'd0, h};
      default:  r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gecko_load_writeback_if.sv
// Handshake bundle between execute/memory, the load-completion stage and writeback.
interface gecko_load_writeback_if #(parameter int QUEUE_DEPTH = 4) ();
  import gecko_load_writeback_pkg::*;

  logic                               mem_op_valid;
  logic                               mem_op_ready;
  gecko_mem_operation_t               mem_op_data;
  logic                               mem_op_speculative;
  logic                               mem_rsp_valid;
  logic                               mem_rsp_ready;
  logic [31:0]                        mem_rsp_data;
  logic                               branch_valid;
  gecko_branch_signal_t               branch_signal;
  logic                               wb_valid;
  logic                               wb_ready;
  gecko_operation_t                   wb_data;
  logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending_count;

  modport master (
    output mem_op_valid, mem_op_data, mem_op_speculative,
           mem_rsp_valid, mem_rsp_data, branch_valid, branch_signal, wb_ready,
    input  mem_op_ready, mem_rsp_ready, wb_valid, wb_data, pending_count
  );

  modport slave (
    input  mem_op_valid, mem_op_data, mem_op_speculative,
           mem_rsp_valid, mem_rsp_data, branch_valid, branch_signal, wb_ready,
    output mem_op_ready, mem_rsp_ready, wb_valid, wb_data, pending_count
  );
endinterface

// File: rtl/gecko_load_writeback_queue.sv
// In-order circular FIFO of outstanding loads with broadcast speculation
// kill/clear applied to every slot.
module gecko_load_queue
  import gecko_load_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  gecko_load_entry_t push_entry,
  input  logic              pop,
  input  logic              kill_speculative,
  input  logic              clear_speculative,
  output gecko_load_entry_t head,
  output logic [CW-1:0]     count
);

  gecko_load_entry_t entries [DEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;

  assign head = entries[head_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry storage has no reset; occupancy comes from count, so stale slots are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_speculative && entries[i].speculative) entries[i].killed <= 1'b1;
      if (clear_speculative) entries[i].speculative <= 1'b0;
    end
    if (push) entries[tail_ptr] <= push_entry;
  end

endmodule

// File: rtl/gecko_load_writeback.sv
// Load-completion stage: queues issued loads, pairs them in order with memory
// responses, formats the data and presents it to register writeback.
module gecko_load_writeback
  import gecko_load_writeback_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  gecko_load_writeback_if.slave  bus
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  gecko_load_entry_t head;
  gecko_load_entry_t push_entry;
  logic [CW-1:0]     count;
  logic              push, pop, mispredict, commit, load_out;
  logic              wb_valid;
  gecko_operation_t  wb_data;

  assign mispredict = bus.branch_valid &  bus.branch_signal.branch;
  assign commit     = bus.branch_valid & ~bus.branch_signal.branch;

  assign bus.mem_op_ready  = (count < CW'(QUEUE_DEPTH));
  assign bus.mem_rsp_ready = (count != '0) & (head.killed | ~wb_valid | bus.wb_ready);
  assign push     = bus.mem_op_valid  & bus.mem_op_ready;
  assign pop      = bus.mem_rsp_valid & bus.mem_rsp_ready;
  assign load_out = pop & ~head.killed;

  // An op arriving alongside a branch event is resolved before it is stored.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    push_entry             = '0;
    push_entry.op          = bus.mem_op_data;
    push_entry.speculative = bus.mem_op_speculative & ~commit;
    push_entry.killed      = bus.mem_op_speculative & mispredict;
  end

  gecko_load_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk               (clk),
    .rst_n             (rst_n),
    .push              (push),
    .push_entry        (push_entry),
    .pop               (pop),
    .kill_speculative  (mispredict),
    .clear_speculative (commit),
    .head              (head),
    .count             (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
    end else if (load_out) begin
      wb_valid            <= ~(mispredict & head.speculative);
      wb_data.value       <= gecko_get_load_result(bus.mem_rsp_data, head.op.offset, head.op.op);
      wb_data.addr        <= head.op.addr;
      wb_data.speculative <= head.speculative & ~commit;
    end else begin
      // Mispredict on a speculative held result is the only valid withdrawal.
      if ((wb_valid & bus.wb_ready) | (mispredict & wb_data.speculative)) wb_valid <= 1'b0;
      if (commit) wb_data.speculative <= 1'b0;
    end
  end

  assign bus.wb_valid      = wb_valid;
  assign bus.wb_data       = wb_data;
  assign bus.pending_count = count;

endmodule

// File: tb/tb_gecko_load_writeback.sv
// Scoreboard bench for gecko_load_writeback: expected writebacks are queued as
// responses are driven and popped by a monitor on every accepted writeback.
module tb_gecko_load_writeback;
  import gecko_load_writeback_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  gecko_operation_t sb[$];

  always #5 clk = ~clk;

  gecko_load_writeback_if #(.QUEUE_DEPTH(4)) bus ();
  gecko_load_writeback #(.QUEUE_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: a writeback transfers on the edge after a negedge with valid&ready.
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid && bus.wb_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got %h with nothing expected", bus.wb_data);
      end else begin
        gecko_operation_t exp;
        exp = sb.pop_front();
        if (bus.wb_data !== exp) begin
          bad++;
          $display("FAIL wb_data: got %h expected %h", bus.wb_data, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input gecko_load_op_t ld,
                       input logic [1:0] off, input logic spec);
    int n = 0;
    bus.mem_op_valid       = 1'b1;
    bus.mem_op_data        = '{addr: rd, op: ld, offset: off};
    bus.mem_op_speculative = spec;
    while (!bus.mem_op_ready && n < 20) begin tick(); n++; end
    if (!bus.mem_op_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout: mem_op_ready stuck at %b, required 1", bus.mem_op_ready);
    end
    tick();
    bus.mem_op_valid       = 1'b0;
    bus.mem_op_speculative = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    int n = 0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = data;
    while (!bus.mem_rsp_ready && n < 20) begin tick(); n++; end
    if (!bus.mem_rsp_ready) begin
      total++; bad++;
      $display("FAIL respond_timeout: mem_rsp_ready stuck at %b, required 1", bus.mem_rsp_ready);
    end
    tick();
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic branch(input logic mispred);
    bus.branch_valid         = 1'b1;
    bus.branch_signal.branch = mispred;
    tick();
    bus.branch_valid         = 1'b0;
    bus.branch_signal.branch = 1'b0;
  endtask

  task automatic expect_count(input string name, input logic [2:0] exp);
    total++;
    if (bus.pending_count !== exp) begin
      bad++;
      $display("FAIL %s: pending_count=%0d required %0d", name, bus.pending_count, exp);
    end
  endtask

  task automatic expect_bit(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    #1;
    expect_count("reset_count", 3'd0);
    expect_bit("reset_wb_valid", bus.wb_valid, 1'b0);
    expect_bit("reset_rsp_ready", bus.mem_rsp_ready, 1'b0);
    expect_bit("reset_op_ready", bus.mem_op_ready, 1'b1);
    total++;
    if (bus.wb_data !== '0) begin
      bad++;
      $display("FAIL reset_wb_data: got %h required 0", bus.wb_data);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    bus.wb_ready = 1'b1;
    issue(5'd5, LOAD_LW, 2'd0, 1'b0);
    sb.push_back('{value: 32'hDEADBEEF, addr: 5'd5, speculative: 1'b0});
    respond(32'hDEADBEEF);
    expect_bit("lw_latency_valid", bus.wb_valid, 1'b1);
    total++;
    if (bus.wb_data !== 38'({32'hDEADBEEF, 5'd5, 1'b0})) begin
      bad++;
      $display("FAIL lw_latency_data: got %h required %h", bus.wb_data, {32'hDEADBEEF, 5'd5, 1'b0});
    end
    tick();
  endtask

  task automatic test_extend();
    bus.wb_ready = 1'b1;
    issue(5'd1, LOAD_LB, 2'd3, 1'b0);
    sb.push_back('{value: 32'hFFFFFF80, addr: 5'd1, speculative: 1'b0});
    respond(32'h80FF0000);
    issue(5'd2, LOAD_LBU, 2'd3, 1'b0);
    sb.push_back('{value: 32'h00000080, addr: 5'd2, speculative: 1'b0});
    respond(32'h80FF0000);
    issue(5'd3, LOAD_LH, 2'd2, 1'b0);
    sb.push_back('{value: 32'hFFFF8001, addr: 5'd3, speculative: 1'b0});
    respond(32'h80011234);
    issue(5'd4, LOAD_LHU, 2'd0, 1'b0);
    sb.push_back('{value: 32'h00001234, addr: 5'd4, speculative: 1'b0});
    respond(32'h80011234);
    tick();
  endtask

  task automatic test_full();
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) issue(5'(10 + i), LOAD_LW, 2'd0, 1'b0);
    expect_count("full_count", 3'd4);
    expect_bit("full_op_ready", bus.mem_op_ready, 1'b0);
    // Pop at full together with a pending push: only the pop happens this edge.
    bus.mem_op_valid  = 1'b1;
    bus.mem_op_data   = '{addr: 5'd14, op: LOAD_LW, offset: 2'd0};
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_000A;
    sb.push_back('{value: 32'h0000_000A, addr: 5'd10, speculative: 1'b0});
    tick();
    bus.mem_rsp_valid = 1'b0;
    expect_count("full_pop_no_push", 3'd3);
    expect_bit("full_op_ready_after_pop", bus.mem_op_ready, 1'b1);
    tick();
    bus.mem_op_valid = 1'b0;
    expect_count("full_refill", 3'd4);
    for (int i = 1; i < 5; i++) begin
      sb.push_back('{value: 32'(10 + i), addr: 5'(10 + i), speculative: 1'b0});
      respond(32'(10 + i));
    end
    expect_count("full_drained", 3'd0);
    tick();
  endtask

  task automatic test_back_to_back();
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) issue(5'(20 + i), LOAD_LW, 2'd0, 1'b0);
    bus.mem_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rsp_data = 32'hA000_0000 + 32'(i);
      sb.push_back('{value: 32'hA000_0000 + 32'(i), addr: 5'(20 + i), speculative: 1'b0});
      expect_bit("b2b_rsp_ready", bus.mem_rsp_ready, 1'b1);
      tick();
    end
    bus.mem_rsp_valid = 1'b0;
    expect_count("b2b_count", 3'd0);
    tick();
  endtask

  task automatic test_mispredict();
    bus.wb_ready = 1'b1;
    issue(5'd6, LOAD_LW, 2'd0, 1'b0);
    issue(5'd7, LOAD_LW, 2'd0, 1'b1);
    issue(5'd8, LOAD_LW, 2'd0, 1'b1);
    branch(1'b1);
    expect_count("mispred_count_kept", 3'd3);
    sb.push_back('{value: 32'h1111_1111, addr: 5'd6, speculative: 1'b0});
    respond(32'h1111_1111);
    respond(32'h2222_2222);
    respond(32'h3333_3333);
    expect_count("mispred_count_zero", 3'd0);
    tick();
    expect_bit("mispred_no_output", bus.wb_valid, 1'b0);
  endtask

  task automatic test_commit_and_withdraw();
    bus.wb_ready             = 1'b1;
    bus.branch_valid         = 1'b1;
    bus.branch_signal.branch = 1'b0;
    issue(5'd9, LOAD_LW, 2'd0, 1'b1);
    bus.branch_valid = 1'b0;
    sb.push_back('{value: 32'h5555_AAAA, addr: 5'd9, speculative: 1'b0});
    respond(32'h5555_AAAA);
    tick();
    bus.wb_ready = 1'b0;
    issue(5'd12, LOAD_LW, 2'd0, 1'b1);
    respond(32'h7777_0000);
    expect_bit("held_valid", bus.wb_valid, 1'b1);
    expect_bit("held_spec", bus.wb_data.speculative, 1'b1);
    branch(1'b1);
    expect_bit("withdraw_valid", bus.wb_valid, 1'b0);
    bus.wb_ready = 1'b1;
    tick();
  endtask

  task automatic test_backpressure_and_reset();
    gecko_operation_t held;
    bus.wb_ready = 1'b0;
    issue(5'd16, LOAD_LW, 2'd0, 1'b0);
    issue(5'd17, LOAD_LW, 2'd0, 1'b0);
    respond(32'hCAFE_0001);
    held = '{value: 32'hCAFE_0001, addr: 5'd16, speculative: 1'b0};
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hCAFE_0002;
    for (int i = 0; i < 5; i++) begin
      expect_bit("stall_rsp_ready", bus.mem_rsp_ready, 1'b0);
      total++;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== held) begin
        bad++;
        $display("FAIL stall_hold: valid=%b data=%h required 1 %h", bus.wb_valid, bus.wb_data, held);
      end
      tick();
    end
    sb.push_back(held);
    sb.push_back('{value: 32'hCAFE_0002, addr: 5'd17, speculative: 1'b0});
    bus.wb_ready = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    tick();
    // Second round: reset lands while a result is held and a load is pending.
    bus.wb_ready = 1'b0;
    issue(5'd18, LOAD_LW, 2'd0, 1'b0);
    issue(5'd19, LOAD_LW, 2'd0, 1'b0);
    respond(32'hBEEF_0000);
    #2 rst_n = 1'b0;
    #1;
    expect_bit("rst_mid_wb_valid", bus.wb_valid, 1'b0);
    expect_count("rst_mid_count", 3'd0);
    expect_bit("rst_mid_op_ready", bus.mem_op_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    tick();
    issue(5'd21, LOAD_LHU, 2'd2, 1'b0);
    sb.push_back('{value: 32'h0000_BEEF, addr: 5'd21, speculative: 1'b0});
    respond(32'hBEEF_0000);
    tick();
  endtask

  initial begin
    bus.mem_op_valid       = 1'b0;
    bus.mem_op_data        = '0;
    bus.mem_op_speculative = 1'b0;
    bus.mem_rsp_valid      = 1'b0;
    bus.mem_rsp_data       = '0;
    bus.branch_valid       = 1'b0;
    bus.branch_signal      = '0;
    bus.wb_ready           = 1'b0;
    test_reset();
    test_lw();
    test_extend();
    test_full();
    test_back_to_back();
    test_mispredict();
    test_commit_and_withdraw();
    test_backpressure_and_reset();
    tick();
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d writebacks never seen, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
